logic_unit_resp: RTL and testbench

Buffered responder for 20-bit bitwise logic requests. It accepts operand pairs and an opcode over a valid/ready request channel and computes the bitwise result. Results are queued in a small in-order FIFO and returned over a valid/ready response channel. It sits between the CPU's operand fetch/issue stage and writeback as the handshaked replacement for the bare combinational AND path, and it provides backpressure in both directions.

---
 rtl/logic_unit_resp_if.sv | 25 ++
 rtl/logic_unit_resp.sv | 104 ++++++++++
 tb/tb_logic_unit_resp.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_resp_if.sv
// Request/response handshake bundle for the buffered bitwise logic responder.
// The master side issues operands and consumes results; the slave side is the responder.
interface logic_unit_resp_if #(
    parameter int WIDTH = 20
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_zero
    );
endinterface

// File: rtl/logic_unit_resp.sv
// Buffered bitwise logic responder.
// Each accepted request computes AND/OR/XOR/ANDN of its operands. The result and its
// zero flag go into a small in-order FIFO that drains over the response channel.
// req_ready depends only on the registered occupancy, so a pop on a full FIFO frees
// a slot for the following cycle, never the same one.
module logic_unit_resp #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_resp_if.slave    bus,
    output logic [15:0]         op_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

    typedef struct packed {
        logic             zero;
        logic [WIDTH-1:0] y;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             pop;

    assign bus.req_ready = (cnt < DEPTH_C);
    assign bus.rsp_valid = (cnt != '0);
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    // Bitwise result of the request currently on the request channel.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // through it leaves a value unassigned and no latch is inferred.
        result = '0;
        case (op_e'(bus.req_op))
            OP_AND:  result = bus.req_a & bus.req_b;
            OP_OR:   result = bus.req_a | bus.req_b;
            OP_XOR:  result = bus.req_a ^ bus.req_b;
            OP_ANDN: result = bus.req_a & ~bus.req_b;
            default: result = '0;
        endcase
    end

    // Head-of-queue output, forced to zero while nothing is queued.
    always_comb begin
        bus.rsp_y    = '0;
        bus.rsp_zero = 1'b0;
        if (bus.rsp_valid) begin
            bus.rsp_y    = mem[rd_ptr].y;
            bus.rsp_zero = mem[rd_ptr].zero;
        end
    end

    // Result storage: written on accept; flushed on reset so stale results never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // pre-edge values regardless of process ordering.
        if (!rst_n) begin
            // NOTE: the storage array is reset here on purpose; a flushed queue must
            // hold zeros, which costs a reset on each entry rather than a plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= '{zero: (result == '0), y: result};
        end
    end

    // Pointers, occupancy and the delivered-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                op_count <= op_count + 16'd1;
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_unit_resp.sv
// Self-checking bench for logic_unit_resp: a queue-based reference model is compared
// against the DUT on every falling edge, with literal expectations for directed cases.
module tb_logic_unit_resp;
    localparam int WIDTH = 20;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] op_count;
    logic        cmp_en;
    int          checks;
    int          errors;

    logic_unit_resp_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results queued in request order, counter of delivered responses.
    logic [WIDTH-1:0] mq [$];
    logic [15:0]      m_ops;

    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        bit pp;
        if (!rst_n) begin
            mq.delete();
            m_ops = '0;
        end else begin
            acc = bus.req_valid && (mq.size() < DEPTH);
            pp  = bus.rsp_ready && (mq.size() != 0);
            if (pp) begin
                void'(mq.pop_front());
                m_ops = m_ops + 16'd1;
            end
            if (acc) mq.push_back(ref_op(bus.req_a, bus.req_b, bus.req_op));
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(mq.size() < DEPTH));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(mq.size() != 0));
            check("rsp_y",     32'(bus.rsp_y),     (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("rsp_zero",  32'(bus.rsp_zero),  (mq.size() != 0) ? 32'(mq[0] == '0) : 32'd0);
            check("op_count",  32'(op_count),      32'(m_ops));
        end
    end

    // Apply inputs, let one rising edge consume them, return 1 time unit after it.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic r);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.rsp_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulse_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] pa [2];
    logic [WIDTH-1:0] exp_y [8];
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [1:0]       rop;

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        idle_inputs();
        #3;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_y",     32'(bus.rsp_y),     32'd0);
        check("reset rsp_zero",  32'(bus.rsp_zero),  32'd0);
        check("reset op_count",  32'(op_count),      32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Basic AND.
        cyc(1'b1, 20'hAAAAA, 20'h55555, 2'b00, 1'b1);
        check("and rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("and rsp_y",     32'(bus.rsp_y),     32'h00000);
        check("and rsp_zero",  32'(bus.rsp_zero),  32'd1);
        cyc(1'b0, '0, '0, 2'b00, 1'b1);
        check("and op_count",  32'(op_count),      32'd1);
        check("and drained",   32'(bus.rsp_valid), 32'd0);

        // All ops on two operand pairs, streamed at one per cycle.
        exp_y = '{20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h00000,
                  20'h00000, 20'hFFFFF, 20'hFFFFF, 20'h00000};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i < 4) ? 20'hFFFFF : 20'h00000, 20'hFFFFF, 2'(i % 4), 1'b1);
            check($sformatf("ops rsp_y[%0d]", i),    32'(bus.rsp_y),    32'(exp_y[i]));
            check($sformatf("ops rsp_zero[%0d]", i), 32'(bus.rsp_zero), 32'(exp_y[i] == '0));
        end
        cyc(1'b0, '0, '0, 2'b00, 1'b1);

        // Fill and backpressure.
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 20'(k), 20'h0, 2'b01, 1'b0);
        end
        check("full req_ready", 32'(bus.req_ready), 32'd0);
        cyc(1'b1, 20'h5, 20'h0, 2'b01, 1'b0);
        check("full no accept ready", 32'(bus.req_ready), 32'd0);
        check("full head",            32'(bus.rsp_y),     32'h00001);
        cyc(1'b1, 20'h6, 20'h0, 2'b01, 1'b1);
        check("pop frees ready",      32'(bus.req_ready), 32'd1);
        check("pop next head",        32'(bus.rsp_y),     32'h00002);
        for (int k = 3; k <= 5; k++) begin
            cyc(1'b0, '0, '0, 2'b00, 1'b1);
            check($sformatf("drain head %0d", k), 32'(bus.rsp_y), (k <= 4) ? 32'(k) : 32'd0);
        end
        check("drain empty", 32'(bus.rsp_valid), 32'd0);

        // Simultaneous push/pop with cnt=2 for 10 cycles; pointers wrap.
        pulse_reset();
        pa[0] = 20'(($urandom));
        pa[1] = 20'(($urandom));
        cyc(1'b1, pa[0], 20'h0, 2'b01, 1'b0);
        cyc(1'b1, pa[1], 20'h0, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 20'(($urandom)), 20'(($urandom)), 2'($urandom_range(3)), 1'b1);
            if (i == 0) check("stream first out", 32'(bus.rsp_y), 32'(pa[1]));
        end
        check("stream op_count",  32'(op_count),      32'd10);
        check("stream req_ready", 32'(bus.req_ready), 32'd1);
        check("stream rsp_valid", 32'(bus.rsp_valid), 32'd1);

        // Asynchronous reset with three entries queued.
        idle_inputs();
        for (int k = 0; k < 4; k++) cyc(1'b0, '0, '0, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 20'hF000F, 20'h0, 2'b01, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async rsp_y",     32'(bus.rsp_y),     32'd0);
        check("async op_count",  32'(op_count),      32'd0);
        check("async req_ready", 32'(bus.req_ready), 32'd1);
        #2 rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        cyc(1'b1, 20'h12345, 20'h0F0F0, 2'b10, 1'b0);
        check("post-reset own y", 32'(bus.rsp_y), 32'h1D3B5);
        cyc(1'b0, '0, '0, 2'b00, 1'b1);
        check("post-reset only one", 32'(bus.rsp_valid), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            ra  = 20'($urandom);
            rb  = ($urandom_range(7) == 0) ? ra : 20'($urandom);
            rop = 2'($urandom_range(3));
            cyc(1'($urandom_range(3) != 0), ra, rb, rop, 1'($urandom_range(2) != 0));
        end

        // op_count wraps after 65536 pops.
        pulse_reset();
        for (int i = 0; i < 65537; i++) begin
            cyc(1'b1, 20'(i), 20'h0, 2'b01, 1'b1);
        end
        check("wrap op_count 0", 32'(op_count), 32'h0000);
        cyc(1'b0, '0, '0, 2'b00, 1'b1);
        check("wrap op_count 1", 32'(op_count), 32'h0001);
        check("wrap empty",      32'(bus.rsp_valid), 32'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
